ifu_axi_fetch: RTL and testbench
================================

// Module: ifu_axi_fetch
// PURPOSE
//  Multi-cycle instruction fetch stage between the PC unit and the decoder. Takes a PC
//  from the PC unit and issues one AXI4-Lite read (AR/R) to instruction memory.
//  Presents the returned instruction to the decoder through a valid/ready handshake.
//  Holds one instruction until the decoder accepts it.
// PARAMETERS
//  PC_W      32            PC / read-address width
//  INST_W    32            instruction / read-data width
//  NOP_INST  32'h00000013  value driven on inst_o when no fetched instruction is held
//  CNT_W     32            width of the completed-fetch counter
// PORTS
//  clk_i         in   1       clock; all logic on rising edge
//  rst_i         in   1       reset, synchronous, active-low
//  pc_i          in   PC_W    fetch address from the PC unit
//  pc_valid_i    in   1       pc_i is valid
//  pc_ready_o    out  1       fetch accepts pc_i this cycle
//  araddr_o      out  PC_W    AXI read address
//  arvalid_o     out  1       AXI read-address valid
//  arready_i     in   1       AXI read-address ready
//  rdata_i       in   INST_W  AXI read data
//  rresp_i       in   2       AXI read response; 2'b00 = OKAY
//  rvalid_i      in   1       AXI read-data valid
//  rready_o      out  1       AXI read-data ready
//  inst_o        out  INST_W  instruction to the decoder
//  pc_o          out  PC_W    PC of inst_o
//  inst_valid_o  out  1       inst_o/pc_o valid
//  inst_ready_i  in   1       decoder accepts inst_o
//  err_o         out  2       with inst_valid_o: 00 none, 01 misaligned PC, 10 bus error
//  fetch_cnt_o   out  CNT_W   count of instructions handed to the decoder
// BEHAVIOUR
//  Reset (rst_i==0 at a clock edge): state=IDLE, arvalid_o=rready_o=inst_valid_o=0,
//    inst_o=NOP_INST, pc_o=0, araddr_o=0, err_o=0, fetch_cnt_o=0. Reset mid-transaction
//    abandons it: a later rvalid_i is ignored because rready_o=0 in IDLE.
//  FSM IDLE/ADDR/DATA/HOLD; pc_ready_o = (IDLE) | (HOLD & inst_ready_i), combinational.
//  IDLE: PC accept (pc_valid_i & pc_ready_o) registers pc_i into pc_q/araddr_o.
//    If pc_i[1:0]!=0 -> HOLD with inst=NOP_INST, err=01; no bus cycle. Otherwise -> ADDR.
//  ADDR: arvalid_o=1. araddr_o stays stable until arready_i. On arready_i -> DATA.
//  DATA: rready_o=1. On rvalid_i, latch inst=rdata_i and err=(rresp_i!=0)?10:00 -> HOLD.
//    On bus error, inst_o is forced to NOP_INST.
//  HOLD: inst_valid_o=1. inst_o, pc_o and err_o are stable until accepted. On inst_ready_i,
//    fetch_cnt_o increments by 1 (wraps modulo 2^CNT_W); error fetches also count.
//    Accept with pc_valid_i in the same cycle: the next PC is captured and the FSM moves
//    directly to ADDR, or to HOLD if misaligned. There is no bubble through IDLE.
//    Accept without pc_valid_i -> IDLE; inst_o returns to NOP_INST, err_o to 00.
//  Latency, aligned PC with immediate arready/rvalid: PC accepted at edge 0, arvalid_o
//    high cycle 1, rready_o high cycle 2, inst_valid_o high cycle 3.
//  Misaligned PC: inst_valid_o high the cycle after accept.
//  Every output is registered except pc_ready_o. arvalid_o and rready_o are never high
//    in the same cycle. At most one outstanding read.
//  pc_valid_i in ADDR/DATA/HOLD without inst_ready_i is not accepted (pc_ready_o=0).
//  The upstream unit holds pc_i until the PC is accepted.
// TESTING
//  1 Reset: hold rst_i=0 for 3 cycles with random inputs -> all outputs at reset values,
//    inst_o=32'h13.
//  2 Basic: pc_i=0x80000000, arready/rvalid held 1, rdata=0x00500093 -> araddr_o=
//    0x80000000 in cycle 1; inst_o=0x00500093, pc_o=0x80000000, inst_valid_o in cycle 3.
//    Decoder accepts -> fetch_cnt_o=1.
//  3 Stalls: arready delayed 4 cycles, rvalid 3, inst_ready 5 -> araddr_o/inst_o stable
//    throughout; exactly one AR handshake; fetch_cnt_o=1.
//  4 Back-to-back: 0x80000000 then 0x80000004 offered while HOLD is accepted ->
//    arvalid_o rises the next cycle with no IDLE cycle; fetch_cnt_o=2.
//  5 Errors: pc_i=0x80000002 -> no arvalid_o, err_o=01, inst_o=0x13 next cycle.
//    rresp_i=2'b10 -> err_o=10, inst_o=0x13.
//  6 Reset mid-read: rst_i=0 in DATA, then a late rvalid_i=1 -> it is ignored, state
//    IDLE, inst_valid_o=0.

Source files
------------

// File: rtl/ifu_axi_fetch_if.sv
// rtl/ifu_axi_fetch_if.sv - PC, AXI4-Lite read and decoder handshake bundle for ifu_axi_fetch
interface ifu_axi_fetch_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 32
);
    logic [PC_W-1:0]   pc_i;
    logic              pc_valid_i;
    logic              pc_ready_o;
    logic [PC_W-1:0]   araddr_o;
    logic              arvalid_o;
    logic              arready_i;
    logic [INST_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rvalid_i;
    logic              rready_o;
    logic [INST_W-1:0] inst_o;
    logic [PC_W-1:0]   pc_o;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [1:0]        err_o;
    logic [CNT_W-1:0]  fetch_cnt_o;

    // master: the fetch unit itself (it is the AXI read master)
    modport master (
        input  pc_i, pc_valid_i, arready_i, rdata_i, rresp_i, rvalid_i, inst_ready_i,
        output pc_ready_o, araddr_o, arvalid_o, rready_o, inst_o, pc_o, inst_valid_o,
               err_o, fetch_cnt_o
    );

    // slave: PC unit, instruction memory and decoder seen together
    modport slave (
        output pc_i, pc_valid_i, arready_i, rdata_i, rresp_i, rvalid_i, inst_ready_i,
        input  pc_ready_o, araddr_o, arvalid_o, rready_o, inst_o, pc_o, inst_valid_o,
               err_o, fetch_cnt_o
    );
endinterface

// File: rtl/ifu_axi_fetch.sv
// rtl/ifu_axi_fetch.sv - single-outstanding AXI4-Lite instruction fetch stage with one-entry hold
module ifu_axi_fetch #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
    parameter int                CNT_W    = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    ifu_axi_fetch_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   araddr_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [INST_W-1:0] inst_q;
    logic [PC_W-1:0]   pc_q;
    logic              inst_valid_q;
    logic [1:0]        err_q;
    logic [CNT_W-1:0]  fetch_cnt_q;

    logic pc_ready;
    logic pc_accept;
    logic misaligned;

    // A held instruction being accepted frees the slot in the same cycle.
    assign pc_ready   = (state == IDLE) || ((state == HOLD) && bus.inst_ready_i);
    assign pc_accept  = bus.pc_valid_i && pc_ready;
    assign misaligned = |bus.pc_i[1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_q       <= NOP_INST;
            pc_q         <= '0;
            inst_valid_q <= 1'b0;
            err_q        <= 2'b00;
            fetch_cnt_q  <= '0;
        end else begin
            case (state)
                ADDR: begin
                    if (bus.arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bus.rvalid_i) begin
                        rready_q     <= 1'b0;
                        inst_valid_q <= 1'b1;
                        state        <= HOLD;
                        if (bus.rresp_i != 2'b00) begin
                            inst_q <= NOP_INST;
                            err_q  <= 2'b10;
                        end else begin
                            inst_q <= bus.rdata_i;
                            err_q  <= 2'b00;
                        end
                    end
                end
                HOLD: begin
                    if (bus.inst_ready_i) begin
                        fetch_cnt_q  <= fetch_cnt_q + CNT_W'(1);
                        inst_valid_q <= 1'b0;
                        inst_q       <= NOP_INST;
                        err_q        <= 2'b00;
                        state        <= IDLE;
                    end
                end
                default: ;
            endcase

            // Capturing a new PC overrides the HOLD->IDLE fall-back above.
            if (pc_accept) begin
                araddr_q <= bus.pc_i;
                pc_q     <= bus.pc_i;
                inst_q   <= NOP_INST;
                if (misaligned) begin
                    state        <= HOLD;
                    inst_valid_q <= 1'b1;
                    err_q        <= 2'b01;
                end else begin
                    state        <= ADDR;
                    arvalid_q    <= 1'b1;
                    inst_valid_q <= 1'b0;
                    err_q        <= 2'b00;
                end
            end
        end
    end

    assign bus.pc_ready_o   = pc_ready;
    assign bus.araddr_o     = araddr_q;
    assign bus.arvalid_o    = arvalid_q;
    assign bus.rready_o     = rready_q;
    assign bus.inst_o       = inst_q;
    assign bus.pc_o         = pc_q;
    assign bus.inst_valid_o = inst_valid_q;
    assign bus.err_o        = err_q;
    assign bus.fetch_cnt_o  = fetch_cnt_q;
endmodule

// File: tb/tb_ifu_axi_fetch.sv
// tb/tb_ifu_axi_fetch.sv - directed and randomized scoreboard bench for ifu_axi_fetch
module tb_ifu_axi_fetch;
    localparam int          PC_W   = 32;
    localparam int          INST_W = 32;
    localparam int          CNT_W  = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_axi_fetch_if #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

    ifu_axi_fetch #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  err;
    } exp_t;

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [31:0] ar_q[$];
    bit          mon_en = 0, auto_en = 0, offer_en = 0;
    int          n_acc = 0;
    int          ar_hs_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents and its error map.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit bus_err(input logic [31:0] a);
        return (a[4:2] == 3'd3);
    endfunction

    // What the decoder must eventually see for a given accepted PC.
    function automatic exp_t model(input logic [31:0] p);
        exp_t e;
        e.pc = p;
        if (p[1:0] != 2'b00) begin
            e.inst = NOP; e.err = 2'b01;
        end else if (bus_err(p)) begin
            e.inst = NOP; e.err = 2'b10;
        end else begin
            e.inst = mem_word(p); e.err = 2'b00;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_pc();
        logic [31:0] p;
        p = $urandom;
        if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
        else                           p[1:0] = 2'b00;
        return p;
    endfunction

    task automatic clear_inputs();
        bus.pc_i = '0; bus.pc_valid_i = 0; bus.arready_i = 0; bus.rdata_i = '0;
        bus.rresp_i = 2'b00; bus.rvalid_i = 0; bus.inst_ready_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        #3;
        if (bus.arvalid_o && bus.arready_i) ar_hs_cnt++;
    end

    // Random stimulus: PC unit, memory responder and decoder back-pressure.
    bit          have_pend = 0;
    logic [31:0] pend_addr = '0;
    bit          pc_taken = 0;

    always @(negedge clk) begin
        if (auto_en) begin
            bus.inst_ready_i = ($urandom_range(0, 2) != 0);
            bus.arready_i    = 1'($urandom_range(0, 1));
            if (have_pend) begin
                bus.rvalid_i = 1'($urandom_range(0, 1));
                bus.rdata_i  = mem_word(pend_addr);
                bus.rresp_i  = bus_err(pend_addr) ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00;
                if (bus.rvalid_i && bus.rready_o) have_pend = 0;
            end else begin
                bus.rvalid_i = 0;
                bus.rdata_i  = $urandom;
                bus.rresp_i  = 2'($urandom_range(0, 3));
            end
            if (bus.arvalid_o && bus.arready_i) begin
                have_pend = 1;
                pend_addr = bus.araddr_o;
            end
            if (pc_taken) begin
                bus.pc_valid_i = 0;
                pc_taken = 0;
            end
            if (!bus.pc_valid_i && offer_en && $urandom_range(0, 2) != 0) begin
                bus.pc_valid_i = 1;
                bus.pc_i = gen_pc();
            end
            #1;
            if (bus.pc_valid_i && bus.pc_ready_o) begin
                sb.push_back(model(bus.pc_i));
                if (bus.pc_i[1:0] == 2'b00) ar_q.push_back(bus.pc_i);
                pc_taken = 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every decoder / AR handshake.
    logic        prev_iv = 0, prev_ir = 0, prev_arv = 0, prev_arr = 0;
    logic [31:0] prev_inst, prev_pc, prev_araddr;
    logic [1:0]  prev_err;

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            exp_t e;
            if (bus.arvalid_o && bus.rready_o) chk("ar_r_overlap", 1, 0);
            chk("fetch_cnt", bus.fetch_cnt_o, n_acc);
            if (prev_iv && !prev_ir) begin
                chk("hold_valid", bus.inst_valid_o, 1);
                chk("hold_inst", bus.inst_o, prev_inst);
                chk("hold_pc", bus.pc_o, prev_pc);
                chk("hold_err", bus.err_o, prev_err);
            end
            if (prev_arv && !prev_arr) begin
                chk("ar_valid_hold", bus.arvalid_o, 1);
                chk("ar_addr_hold", bus.araddr_o, prev_araddr);
            end
            if (bus.inst_valid_o && bus.inst_ready_i) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_inst", bus.inst_o, e.inst);
                    chk("sb_pc", bus.pc_o, e.pc);
                    chk("sb_err", bus.err_o, e.err);
                end
                n_acc++;
            end
            if (bus.arvalid_o && bus.arready_i) begin
                if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
                else                  chk("ar_addr", bus.araddr_o, ar_q.pop_front());
            end
            prev_iv = bus.inst_valid_o; prev_ir = bus.inst_ready_i;
            prev_inst = bus.inst_o; prev_pc = bus.pc_o; prev_err = bus.err_o;
            prev_arv = bus.arvalid_o; prev_arr = bus.arready_i; prev_araddr = bus.araddr_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int ar0;
        int drain;
        clear_inputs();

        // Reset held for three edges with random inputs
        repeat (3) begin
            @(negedge clk);
            bus.pc_i = $urandom; bus.pc_valid_i = 1'($urandom); bus.arready_i = 1'($urandom);
            bus.rdata_i = $urandom; bus.rresp_i = 2'($urandom); bus.rvalid_i = 1'($urandom);
            bus.inst_ready_i = 1'($urandom);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        chk("rst_arvalid", bus.arvalid_o, 0);
        chk("rst_rready", bus.rready_o, 0);
        chk("rst_inst_valid", bus.inst_valid_o, 0);
        chk("rst_inst", bus.inst_o, NOP);
        chk("rst_pc", bus.pc_o, 0);
        chk("rst_araddr", bus.araddr_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_cnt", bus.fetch_cnt_o, 0);
        chk("rst_pc_ready", bus.pc_ready_o, 1);
        rst_n = 1;

        // Basic fetch, immediate memory
        do_reset();
        bus.pc_i = 32'h8000_0000; bus.pc_valid_i = 1; bus.arready_i = 1; bus.rvalid_i = 1;
        bus.rdata_i = 32'h0050_0093;
        #1 chk("basic_pc_ready", bus.pc_ready_o, 1);
        @(negedge clk);
        bus.pc_valid_i = 0;
        chk("basic_c1_arvalid", bus.arvalid_o, 1);
        chk("basic_c1_araddr", bus.araddr_o, 32'h8000_0000);
        chk("basic_c1_rready", bus.rready_o, 0);
        @(negedge clk);
        chk("basic_c2_arvalid", bus.arvalid_o, 0);
        chk("basic_c2_rready", bus.rready_o, 1);
        chk("basic_c2_iv", bus.inst_valid_o, 0);
        @(negedge clk);
        chk("basic_c3_iv", bus.inst_valid_o, 1);
        chk("basic_c3_inst", bus.inst_o, 32'h0050_0093);
        chk("basic_c3_pc", bus.pc_o, 32'h8000_0000);
        chk("basic_c3_err", bus.err_o, 0);
        bus.inst_ready_i = 1;
        @(negedge clk);
        bus.inst_ready_i = 0;
        chk("basic_cnt", bus.fetch_cnt_o, 1);
        chk("basic_idle_iv", bus.inst_valid_o, 0);
        chk("basic_idle_inst", bus.inst_o, NOP);

        // Stalls on AR, R and decoder
        do_reset();
        ar0 = ar_hs_cnt;
        bus.pc_i = 32'h8000_0010; bus.pc_valid_i = 1;
        @(negedge clk);
        bus.pc_valid_i = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_arvalid", bus.arvalid_o, 1);
            chk("stall_araddr", bus.araddr_o, 32'h8000_0010);
            if (i == 4) bus.arready_i = 1;
            @(negedge clk);
        end
        bus.arready_i = 0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_rready", bus.rready_o, 1);
            chk("stall_no_iv", bus.inst_valid_o, 0);
            if (i == 3) begin bus.rvalid_i = 1; bus.rdata_i = 32'h1234_5067; end
            @(negedge clk);
        end
        bus.rvalid_i = 0; bus.rdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            chk("stall_iv", bus.inst_valid_o, 1);
            chk("stall_inst", bus.inst_o, 32'h1234_5067);
            chk("stall_pc", bus.pc_o, 32'h8000_0010);
            if (i == 5) bus.inst_ready_i = 1;
            @(negedge clk);
        end
        bus.inst_ready_i = 0;
        chk("stall_cnt", bus.fetch_cnt_o, 1);
        chk("stall_ar_count", ar_hs_cnt - ar0, 1);

        // Back-to-back: next PC accepted together with the held instruction
        do_reset();
        bus.pc_i = 32'h8000_0000; bus.pc_valid_i = 1; bus.arready_i = 1; bus.rvalid_i = 1;
        bus.rdata_i = 32'h0000_1111;
        @(negedge clk);
        bus.pc_valid_i = 0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_first_inst", bus.inst_o, 32'h0000_1111);
        bus.inst_ready_i = 1; bus.pc_valid_i = 1; bus.pc_i = 32'h8000_0004;
        bus.rdata_i = 32'h0000_2222;
        #1 chk("b2b_pc_ready", bus.pc_ready_o, 1);
        @(negedge clk);
        bus.pc_valid_i = 0; bus.inst_ready_i = 0;
        chk("b2b_arvalid", bus.arvalid_o, 1);
        chk("b2b_araddr", bus.araddr_o, 32'h8000_0004);
        chk("b2b_cnt1", bus.fetch_cnt_o, 1);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_inst", bus.inst_o, 32'h0000_2222);
        chk("b2b_pc", bus.pc_o, 32'h8000_0004);
        bus.inst_ready_i = 1;
        @(negedge clk);
        bus.inst_ready_i = 0;
        chk("b2b_cnt2", bus.fetch_cnt_o, 2);

        // Misaligned PC and bus error
        do_reset();
        bus.pc_i = 32'h8000_0002; bus.pc_valid_i = 1;
        @(negedge clk);
        bus.pc_valid_i = 0;
        chk("mis_iv", bus.inst_valid_o, 1);
        chk("mis_err", bus.err_o, 2'b01);
        chk("mis_inst", bus.inst_o, NOP);
        chk("mis_pc", bus.pc_o, 32'h8000_0002);
        chk("mis_arvalid", bus.arvalid_o, 0);
        bus.inst_ready_i = 1;
        @(negedge clk);
        bus.inst_ready_i = 0;
        chk("mis_after_iv", bus.inst_valid_o, 0);
        chk("mis_after_err", bus.err_o, 0);
        chk("mis_cnt", bus.fetch_cnt_o, 1);
        bus.pc_i = 32'h8000_0008; bus.pc_valid_i = 1; bus.arready_i = 1; bus.rvalid_i = 1;
        bus.rresp_i = 2'b10; bus.rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.pc_valid_i = 0;
        @(negedge clk);
        @(negedge clk);
        chk("berr_iv", bus.inst_valid_o, 1);
        chk("berr_err", bus.err_o, 2'b10);
        chk("berr_inst", bus.inst_o, NOP);
        bus.inst_ready_i = 1;
        @(negedge clk);
        bus.inst_ready_i = 0;
        chk("berr_cnt", bus.fetch_cnt_o, 2);

        // Reset while waiting for read data
        do_reset();
        bus.pc_i = 32'h8000_0020; bus.pc_valid_i = 1; bus.arready_i = 1;
        @(negedge clk);
        bus.pc_valid_i = 0;
        @(negedge clk);
        chk("midrst_rready", bus.rready_o, 1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        bus.rvalid_i = 1; bus.rdata_i = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_rready0", bus.rready_o, 0);
            chk("midrst_iv", bus.inst_valid_o, 0);
            chk("midrst_inst", bus.inst_o, NOP);
            @(negedge clk);
        end
        #1 chk("midrst_idle", bus.pc_ready_o, 1);

        // Randomized traffic against the scoreboard
        do_reset();
        sb.delete(); ar_q.delete();
        n_acc = 0; have_pend = 0; pc_taken = 0;
        prev_iv = 0; prev_arv = 0;
        mon_en = 1; auto_en = 1; offer_en = 1;
        repeat (3000) @(negedge clk);
        offer_en = 0;
        drain = 0;
        while ((sb.size() != 0 || bus.pc_valid_i) && drain < 500) begin
            @(negedge clk);
            drain++;
        end
        chk("drain_sb", sb.size(), 0);
        chk("drain_ar", ar_q.size(), 0);
        @(negedge clk);
        auto_en = 0; mon_en = 0;
        chk("rand_traffic_seen", (n_acc > 100), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
